// File: rtl/turfio_phy_align_if.sv
// Signal bundle between the TURFIO PHY alignment controller and the PHY/fabric side.
// data_valid only qualifies data; there is no backpressure, so a word presented with data_valid=1 is consumed that cycle.
interface turfio_phy_align_if #(
  parameter int NCH   = 3,
  parameter int NBITS = 8
);
  logic                 start;
  logic                 phy_rst;
  logic                 rst_seq_done;
  logic [NCH-1:0]       dly_rdy;
  logic [NCH-1:0]       vtc_rdy;
  logic [NCH-1:0]       en_vtc;
  logic                 start_bitslip;
  logic                 bitslip_done;
  logic [NCH*NBITS-1:0] data;
  logic                 data_valid;
  logic [NCH-1:0]       word_slip;
  logic [NCH-1:0]       aligned;
  logic                 locked;
  logic                 err;
  logic [2:0]           state;

  modport master (
    output start, rst_seq_done, dly_rdy, vtc_rdy, bitslip_done, data, data_valid,
    input  phy_rst, en_vtc, start_bitslip, word_slip, aligned, locked, err, state
  );

  modport slave (
    input  start, rst_seq_done, dly_rdy, vtc_rdy, bitslip_done, data, data_valid,
    output phy_rst, en_vtc, start_bitslip, word_slip, aligned, locked, err, state
  );
endinterface

// File: rtl/turfio_phy_align.sv
// Bring-up sequencer for the native-PHY receive path: PHY reset, ready waits,
// built-in bitslip, then per-channel word alignment against a training word.
module turfio_phy_align #(
  parameter int               NCH        = 3,
  parameter int               NBITS      = 8,
  parameter logic [NBITS-1:0] TRAIN      = NBITS'(8'hA5),
  parameter int               RST_CYCLES = 16,
  parameter int               LOCK_COUNT = 64,
  parameter int               TIMEOUT    = 4096
) (
  input  logic              sys_clk,
  input  logic              rst,
  turfio_phy_align_if.slave bus
);

  localparam int TMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int MW   = $clog2(LOCK_COUNT + 1);
  localparam int SW   = $clog2(NBITS + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] CNT_TOP  = TW'(TMAX - 1);
  localparam logic [MW-1:0] LC_LAST  = MW'(LOCK_COUNT - 1);
  localparam logic [SW-1:0] SLIP_MAX = SW'(NBITS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PHYRST  = 3'd1,
    WAITSEQ = 3'd2,
    WAITDLY = 3'd3,
    WAITVTC = 3'd4,
    BITSLIP = 3'd5,
    ALIGN   = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t                   state_q;
  logic [TW-1:0]            tcnt;
  logic                     phy_rst_q;
  logic [NCH-1:0]           en_vtc_q;
  logic                     start_bitslip_q;
  logic [NCH-1:0]           word_slip_q;
  logic [NCH-1:0]           aligned_q;
  logic                     locked_q;
  logic                     err_q;
  logic [NCH-1:0][MW-1:0]   mcnt;
  logic [NCH-1:0][SW-1:0]   scnt;
  logic [NCH-1:0][2:0]      hold;
  logic                     slip_fail;
  logic                     timed_out;

  always_comb begin
    slip_fail = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (scnt[c] == SLIP_MAX) slip_fail = 1'b1;
    end
  end

  assign timed_out = (tcnt == TO_LAST);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      tcnt            <= '0;
      phy_rst_q       <= 1'b0;
      en_vtc_q        <= '0;
      start_bitslip_q <= 1'b0;
      word_slip_q     <= '0;
      aligned_q       <= '0;
      locked_q        <= 1'b0;
      err_q           <= 1'b0;
      mcnt            <= '0;
      scnt            <= '0;
      hold            <= '0;
    end else begin
      word_slip_q <= '0;
      if (bus.start) begin
        state_q         <= PHYRST;
        tcnt            <= '0;
        phy_rst_q       <= 1'b1;
        en_vtc_q        <= '0;
        start_bitslip_q <= 1'b0;
        aligned_q       <= '0;
        locked_q        <= 1'b0;
        err_q           <= 1'b0;
        mcnt            <= '0;
        scnt            <= '0;
        hold            <= '0;
      end else begin
        // Later assignments of zero on state entry override this saturating count.
        if (tcnt != CNT_TOP) tcnt <= tcnt + 1'b1;
        case (state_q)
          IDLE: ;
          PHYRST: begin
            if (tcnt == RST_LAST) begin
              state_q   <= WAITSEQ;
              phy_rst_q <= 1'b0;
              tcnt      <= '0;
            end
          end
          WAITSEQ: begin
            if (bus.rst_seq_done) begin
              state_q <= WAITDLY;
              tcnt    <= '0;
            end else if (timed_out) begin
              state_q <= DONE;
              err_q   <= 1'b1;
              tcnt    <= '0;
            end
          end
          WAITDLY: begin
            if (&bus.dly_rdy) begin
              state_q  <= WAITVTC;
              en_vtc_q <= '1;
              tcnt     <= '0;
            end else if (timed_out) begin
              state_q <= DONE;
              err_q   <= 1'b1;
              tcnt    <= '0;
            end
          end
          WAITVTC: begin
            if (&bus.vtc_rdy) begin
              state_q         <= BITSLIP;
              start_bitslip_q <= 1'b1;
              tcnt            <= '0;
            end else if (timed_out) begin
              state_q <= DONE;
              err_q   <= 1'b1;
              tcnt    <= '0;
            end
          end
          BITSLIP: begin
            if (bus.bitslip_done) begin
              state_q         <= ALIGN;
              start_bitslip_q <= 1'b0;
              tcnt            <= '0;
            end else if (timed_out) begin
              state_q         <= DONE;
              start_bitslip_q <= 1'b0;
              err_q           <= 1'b1;
              tcnt            <= '0;
            end
          end
          ALIGN: begin
            if (&aligned_q) begin
              state_q  <= DONE;
              locked_q <= 1'b1;
              tcnt     <= '0;
            end else if (slip_fail || timed_out) begin
              state_q <= DONE;
              err_q   <= 1'b1;
              tcnt    <= '0;
            end else begin
              // Aligned channels freeze; the rest count matches or slip and back off.
              for (int c = 0; c < NCH; c++) begin
                if (!aligned_q[c]) begin
                  if (hold[c] != 3'd0) begin
                    hold[c] <= hold[c] - 3'd1;
                  end else if (bus.data_valid) begin
                    if (bus.data[c*NBITS +: NBITS] == TRAIN) begin
                      mcnt[c] <= mcnt[c] + 1'b1;
                      if (mcnt[c] == LC_LAST) aligned_q[c] <= 1'b1;
                    end else begin
                      mcnt[c]        <= '0;
                      word_slip_q[c] <= 1'b1;
                      scnt[c]        <= scnt[c] + 1'b1;
                      hold[c]        <= 3'd4;
                    end
                  end
                end
              end
            end
          end
          DONE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.phy_rst       = phy_rst_q;
  assign bus.en_vtc        = en_vtc_q;
  assign bus.start_bitslip = start_bitslip_q;
  assign bus.word_slip     = word_slip_q;
  assign bus.aligned       = aligned_q;
  assign bus.locked        = locked_q;
  assign bus.err           = err_q;
  assign bus.state         = state_q;

endmodule

// File: doc/turfio_phy_align.md
# turfio_phy_align

Multi-channel bring-up and word-alignment controller for the TURFIO native-PHY receive path. It sequences PHY reset and waits for the reset sequence, delay-ready and VTC-ready. It then runs the built-in bitslip and performs per-channel word alignment against a training pattern, with a timeout on every wait. It sits between the native PHY instance and the control/register fabric, and generalises the single-link test harness to `NCH` channels of `NBITS`-bit words.

## Interface
- `NCH`, 3, number of receive channels (1–8).
- `NBITS`, 8, bits per word from each channel.
- `TRAIN`, 8'hA5, expected training word (`NBITS` wide).
- `RST_CYCLES`, 16, PHY reset assertion length in cycles (≥2).
- `LOCK_COUNT`, 64, consecutive valid matches required for channel alignment (≥1).
- `TIMEOUT`, 4096, cycle limit for each wait/align state.
- `sys_clk` in 1: single clock; all inputs are synchronous to it.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to (re)start the bring-up sequence.
- `phy_rst` out 1: reset to the native PHY.
- `rst_seq_done` in 1: PHY reset sequence complete.
- `dly_rdy` in `NCH`: per-channel delay ready.
- `vtc_rdy` in `NCH`: per-channel VTC ready.
- `en_vtc` out `NCH`: VTC enable, all bits driven identically.
- `start_bitslip` out 1: PHY built-in bitslip request.
- `bitslip_done` in 1: PHY bitslip sync done.
- `data` in `NCH*NBITS`: channel `c` occupies bits `[c*NBITS +: NBITS]`.
- `data_valid` in 1: `data` is valid this cycle.
- `word_slip` out `NCH`: single-cycle pulse that rotates that channel's word boundary by one bit.
- `aligned` out `NCH`: channel alignment achieved.
- `locked` out 1: all channels aligned.
- `err` out 1: sequence failed; sticky until `start` or `rst`.
- `state` out 3: current FSM state encoding.

## Operation
- FSM states and encodings: IDLE=0, PHYRST=1, WAITSEQ=2, WAITDLY=3, WAITVTC=4, BITSLIP=5, ALIGN=6, DONE=7.
- `err` qualifies DONE: DONE with `err`=0 means locked; DONE with `err`=1 means failed.
- **IDLE:** on `start`, go to PHYRST.
- **PHYRST:** assert `phy_rst` for exactly `RST_CYCLES` cycles, then go to WAITSEQ.
- **WAITSEQ:** on `rst_seq_done`=1, go to WAITDLY.
- **WAITDLY:** on `&dly_rdy`, go to WAITVTC. `en_vtc` is asserted on entry to WAITVTC.
- **WAITVTC:** on `&vtc_rdy`, go to BITSLIP.
- **BITSLIP:** `start_bitslip`=1 while in this state. On `bitslip_done`=1, deassert it next cycle and go to ALIGN.
- **ALIGN:** per channel, independently, on each `data_valid` cycle:
  - Match with `TRAIN`: increment a match counter. When it reaches `LOCK_COUNT`, set `aligned[c]`.
  - Mismatch while not aligned: clear the counter, pulse `word_slip[c]` once, increment the slip count, and ignore that channel for the next 4 cycles (holdoff).
  - `aligned[c]`, once set, holds through the end of ALIGN.
- **ALIGN exits:**
  - When `&aligned`, go to DONE and set `locked`=1.
  - A channel whose slip count reaches `NBITS` without aligning sets `err`=1 and the FSM goes to DONE.
- **Timeout:** one shared cycle counter, cleared on every state entry. In WAITSEQ, WAITDLY, WAITVTC, BITSLIP and ALIGN, reaching `TIMEOUT` sets `err`=1 and the FSM goes to DONE.
- **DONE:** outputs hold. `en_vtc` stays asserted.
- **`start` in any state** (including mid-sequence) restarts at PHYRST. It clears `err`, `locked`, `aligned`, all counters, `en_vtc` and `start_bitslip`.

## Timing
- All outputs are registered.
- Reset values: `phy_rst`=0, `en_vtc`=0, `start_bitslip`=0, `word_slip`=0, `aligned`=0, `locked`=0, `err`=0, `state`=IDLE.
- `start` in cycle N: `phy_rst`=1 and `state`=PHYRST from cycle N+1 through N+`RST_CYCLES`.
- Condition inputs are sampled every cycle. A true condition in cycle N gives the new `state` in cycle N+1.
- `word_slip` appears one cycle after the mismatching `data_valid` cycle.
- `locked` rises the same cycle `state` becomes DONE, which is one cycle after the last `aligned` bit is set.
- Simultaneous events:
  - Timeout and success in the same cycle: success wins.
  - `start` and any condition in the same cycle: `start` wins.
- Counter widths: `$clog2(TIMEOUT+1)`, `$clog2(LOCK_COUNT+1)`, and `$clog2(NBITS+1)` per channel. None wraps, because each saturates at its threshold.

## Test plan
- Nominal, `NCH`=3: `start`, `rst_seq_done` after 20 cycles, `dly_rdy`/`vtc_rdy`=3'b111, `bitslip_done` after 10 cycles, data=`TRAIN` every cycle → `locked`=1 with `err`=0; `phy_rst` high exactly 16 cycles.
- Misaligned channel: ch1 sends `TRAIN` rotated by 3 bits; the model rotates the word on each `word_slip` → exactly 3 `word_slip[1]` pulses, `aligned`=3'b111, then `locked`=1.
- Timeout: `vtc_rdy` held at 3'b011 → `err`=1, `state`=DONE after exactly 4096 cycles in WAITVTC; `locked`=0.
- Unalignable: ch0 sends 8'h00 → 8 `word_slip[0]` pulses, `err`=1, `aligned[0]`=0.
- Restart mid-ALIGN: pulse `start` → next cycle `state`=PHYRST, `aligned`=0, `en_vtc`=0, `err`=0.
- Async reset asserted mid-BITSLIP with `sys_clk` stopped → all outputs reach reset values immediately.
